// File: rtl/nvram_uploader.sv
`default_nettype none
// ============================================================================
// nvram_uploader : answers HPS upload reads from a core RAM region while the
//                  core is held paused.                              Rev 1.0
// ============================================================================
module nvram_uploader #(
  parameter logic [7:0] INDEX   = 8'd4,
  parameter int         AW      = 10,
  parameter int         SIZE    = 1024,
  parameter int         BASE    = 0,
  parameter int         RAM_LAT = 2,
  parameter int         TIMEOUT = 4096
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic [24:0]   ioctl_addr,
  input  logic          ioctl_rd,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_dout,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic          busy,
  output logic          done
);

  localparam int                c_TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
  localparam logic [2:0]        c_LAT     = 3'(RAM_LAT);
  localparam logic [31:0]       c_SIZE    = 32'(SIZE);
  localparam logic [AW-1:0]     c_BASE    = AW'(BASE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PAUSE  = 3'd1,
    S_READY  = 3'd2,
    S_FETCH  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_sel_d;
  logic [c_TO_W-1:0] r_to_cnt;
  logic [2:0]        r_lat_cnt;

  logic w_sel;
  logic w_in_range;
  logic w_active;

  assign w_sel      = ioctl_upload && (ioctl_index == INDEX);
  assign w_in_range = ({7'd0, ioctl_addr} < c_SIZE);
  assign w_active   = (r_state == S_PAUSE) || (r_state == S_READY) || (r_state == S_FETCH);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_sel_d    <= 1'b0;
      r_to_cnt   <= '0;
      r_lat_cnt  <= '0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      pause_req  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_sel_d <= w_sel;
      done    <= 1'b0;
      ram_rd  <= 1'b0;
      // Losing the session wins over everything, including a fetch in flight.
      if (w_active && !w_sel) begin
        r_state    <= S_FINISH;
        pause_req  <= 1'b0;
        ioctl_wait <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_sel && !r_sel_d) begin
              r_state    <= S_PAUSE;
              busy       <= 1'b1;
              pause_req  <= 1'b1;
              ioctl_wait <= 1'b1;
              r_to_cnt   <= '0;
            end
          end
          S_PAUSE: begin
            if (pause_ack || (r_to_cnt == c_TO_LAST)) begin
              r_state    <= S_READY;
              ioctl_wait <= 1'b0;
            end else begin
              r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end
          end
          S_READY: begin
            if (ioctl_rd && !ioctl_wait) begin
              if (w_in_range) begin
                r_state    <= S_FETCH;
                ram_addr   <= c_BASE + ioctl_addr[AW-1:0];
                ram_rd     <= 1'b1;
                ioctl_wait <= 1'b1;
                r_lat_cnt  <= '0;
              end else begin
                ioctl_din <= 8'hFF;
              end
            end
          end
          S_FETCH: begin
            // The count starts on the ram_rd cycle, so data is sampled RAM_LAT cycles later.
            if (r_lat_cnt == c_LAT) begin
              r_state    <= S_READY;
              ioctl_din  <= ram_dout;
              ioctl_wait <= 1'b0;
            end else begin
              r_lat_cnt <= r_lat_cnt + 3'd1;
            end
          end
          S_FINISH: r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/nvram_uploader.md
Name: nvram_uploader

Overview:
- Upload-direction counterpart to the ROM download path: serves HPS read requests (ioctl_upload/ioctl_rd) by fetching bytes from a core-side RAM region (high-score/NVRAM) and returning them on ioctl_din.
- Sits between hps_io and the game core's RAM read port.
- Pauses the core while it reads so the RAM snapshot is consistent.

Parameters:
- INDEX, 8'd4, ioctl_index value this block answers to.
- AW, 10, RAM address width.
- SIZE, 1024, bytes exported; requests at addresses >= SIZE return 8'hFF.
- BASE, 0, RAM address of byte 0.
- RAM_LAT, 2, cycles from ram_rd to valid ram_dout (1..7).
- TIMEOUT, 4096, cycles to wait for pause_ack before proceeding anyway.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_index  in  8  session file index.
- ioctl_addr  in  25  requested byte address.
- ioctl_rd  in  1  one-cycle read strobe.
- ioctl_din  out  8  returned byte.
- ioctl_wait  out  1  HPS must not issue ioctl_rd while high.
- ram_addr  out  AW  core RAM address.
- ram_rd  out  1  one-cycle RAM read strobe.
- ram_dout  in  8  core RAM data.
- pause_req  out  1  request core halt.
- pause_ack  in  1  core halted.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.

Behaviour:
- Reset values: ioctl_din=8'h00, ioctl_wait=0, ram_addr=0, ram_rd=0, pause_req=0, busy=0, done=0; state IDLE; counters cleared. RESET mid-session aborts immediately, with no done pulse.
- "sel" = ioctl_upload & (ioctl_index==INDEX).
- IDLE:
  - sel rising -> PAUSE; busy=1, pause_req=1, ioctl_wait=1, timeout counter=0.
- PAUSE:
  - pause_ack=1 or counter reaches TIMEOUT-1 -> READY; ioctl_wait=0 on the following cycle.
- READY:
  - ioctl_rd with ioctl_addr < SIZE: latch address. Next cycle ram_addr=BASE+ioctl_addr[AW-1:0] (mod 2^AW), ram_rd=1 for one cycle, ioctl_wait=1 -> FETCH.
  - ioctl_rd with ioctl_addr >= SIZE (full 25-bit compare): ioctl_din=8'hFF next cycle; no RAM access; ioctl_wait stays 0.
- FETCH:
  - Count RAM_LAT cycles after ram_rd, then capture ram_dout into ioctl_din, drop ioctl_wait -> READY.
  - Read latency seen by HPS: RAM_LAT+2 cycles from ioctl_rd to ioctl_wait low.
- ioctl_din holds its last value until the next read completes.
- ioctl_rd while ioctl_wait=1, or outside READY: ignored.
- sel falls in any state other than IDLE -> FINISH. This takes priority over a simultaneous ioctl_rd, and an in-flight FETCH is abandoned.
- FINISH (1 cycle): pause_req=0, ioctl_wait=0, busy=0, done=1 -> IDLE.
- ioctl_upload with a different index: block stays IDLE with all outputs inactive.
- ram_rd is never asserted outside FETCH entry.
- pause_req is high exactly from PAUSE entry to FINISH.

Test Plan:
- Basic read, RAM_LAT=2, RAM[5]=8'h3C: start sel, pause_ack after 3 cycles, ioctl_rd at addr 5 -> ram_addr=5, one ram_rd pulse, ioctl_din=8'h3C, ioctl_wait low 4 cycles after ioctl_rd.
- Full dump, SIZE=1024, BASE=0x100: read addrs 0..1023 with RAM = addr^8'hA5 -> every byte matches; ram_addr wraps at 2^AW; on upload end, exactly one done pulse, pause_req=0.
- Out-of-range: ioctl_rd at addr 1024 and addr 25'h1000000 -> ioctl_din=8'hFF, ram_rd never asserted.
- Pause timeout: pause_ack held 0, TIMEOUT=16 -> ioctl_wait drops 17 cycles after sel rise; reads still serviced.
- Abort: drop ioctl_upload mid-FETCH -> next cycle FINISH, done=1, then IDLE; the captured byte does not update ioctl_din. Separately, RESET mid-FETCH -> all outputs at reset values next cycle, no done pulse.
- Wrong index: ioctl_index=0 with upload and rd strobes -> pause_req, busy, ram_rd and ioctl_wait remain 0.
